// File: rtl/descrypt_round_seq.sv
// Round sequencer for one descrypt core: latches the salt, then steps 25 iterations
// of 16 DES rounds with the C/D shift schedule and hands the result off downstream.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for a job; in_ready=1
// INIT  | one cycle: clear L/R, load key, counters at 0
// ROUND | round_en every cycle, 400 cycles total
// DONE  | result valid in L/R; held until out_ready
module descrypt_round_seq #(
   parameter int SALT_MSB   = 11,
   parameter int ROUNDS     = 16,
   parameter int ITERATIONS = 25
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   input  logic [SALT_MSB:0] salt_in,
   output logic              in_ready,
   output logic [SALT_MSB:0] salt_out,
   output logic              lr_clear,
   output logic              key_load,
   output logic              round_en,
   output logic              key_shift2,
   output logic              iter_end,
   output logic [3:0]        round_num,
   output logic [4:0]        iter_num,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);
   localparam logic [4:0] ITER_LAST  = 5'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INIT  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   last_round;

   assign last_round = (round_num == ROUND_LAST) && (iter_num == ITER_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      lr_clear   = 1'b0;
      key_load   = 1'b0;
      round_en   = 1'b0;
      key_shift2 = 1'b0;
      iter_end   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = INIT;
         end
         INIT: begin
            lr_clear  = 1'b1;
            key_load  = 1'b1;
            state_nxt = ROUND;
         end
         ROUND: begin
            round_en = 1'b1;
            // single-bit rotations on rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15)
            key_shift2 = !((round_num == 4'd0) || (round_num == 4'd1) ||
                           (round_num == 4'd8) || (round_num == 4'd15));
            iter_end   = (round_num == ROUND_LAST);
            if (last_round) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = in_valid ? INIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         salt_out <= '0;
      end else if (accept) begin
         salt_out <= salt_in;
      end
   end

   // counters freeze at their last values on the final round so DONE reports 15/24
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         round_num <= 4'd0;
         iter_num  <= 5'd0;
      end else if (accept) begin
         round_num <= 4'd0;
         iter_num  <= 5'd0;
      end else if (state == ROUND && !last_round) begin
         if (round_num == ROUND_LAST) begin
            round_num <= 4'd0;
            iter_num  <= iter_num + 5'd1;
         end else begin
            round_num <= round_num + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_descrypt_round_seq.sv
// Directed bench for descrypt_round_seq: reset, single job, key schedule,
// back-to-back accepts, output stall and reset mid-job.
`timescale 1ns/1ps

module tb_descrypt_round_seq;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic [11:0] salt_in;
   logic        in_ready;
   logic [11:0] salt_out;
   logic        lr_clear, key_load, round_en, key_shift2, iter_end;
   logic [3:0]  round_num;
   logic [4:0]  iter_num;
   logic        out_valid;
   logic        out_ready;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [15:0] ks_tab = 16'h7EFC;  // round 0..15 -> 0,0,1,1,1,1,1,1,0,1,1,1,1,1,1,0

   descrypt_round_seq dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .salt_in(salt_in),
      .in_ready(in_ready), .salt_out(salt_out), .lr_clear(lr_clear),
      .key_load(key_load), .round_en(round_en), .key_shift2(key_shift2),
      .iter_end(iter_end), .round_num(round_num), .iter_num(iter_num),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_salt_out",   32'(salt_out),   32'd0);
      chk("rst_lr_clear",   32'(lr_clear),   32'd0);
      chk("rst_key_load",   32'(key_load),   32'd0);
      chk("rst_round_en",   32'(round_en),   32'd0);
      chk("rst_key_shift2", 32'(key_shift2), 32'd0);
      chk("rst_iter_end",   32'(iter_end),   32'd0);
      chk("rst_round_num",  32'(round_num),  32'd0);
      chk("rst_iter_num",   32'(iter_num),   32'd0);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
   endtask

   // Called just after accept edge E0; returns at the negedge sampling cycle E0+402.
   task automatic follow_job(input logic [11:0] salt, output int done_cyc);
      int r, it;
      @(negedge CLK);
      chk("init_lr_clear",  32'(lr_clear),  32'd1);
      chk("init_key_load",  32'(key_load),  32'd1);
      chk("init_round_en",  32'(round_en),  32'd0);
      chk("init_round_num", 32'(round_num), 32'd0);
      chk("init_iter_num",  32'(iter_num),  32'd0);
      chk("init_in_ready",  32'(in_ready),  32'd0);
      chk("init_salt_out",  32'(salt_out),  32'(salt));
      for (int k = 2; k <= 401; k++) begin
         @(negedge CLK);
         r  = (k - 2) % 16;
         it = (k - 2) / 16;
         chk("rnd_round_en",   32'(round_en),   32'd1);
         chk("rnd_round_num",  32'(round_num),  32'(r));
         chk("rnd_iter_num",   32'(iter_num),   32'(it));
         chk("rnd_key_shift2", 32'(key_shift2), 32'(ks_tab[r]));
         chk("rnd_iter_end",   32'(iter_end),   (r == 15) ? 32'd1 : 32'd0);
         chk("rnd_out_valid",  32'(out_valid),  32'd0);
         chk("rnd_lr_clear",   32'(lr_clear),   32'd0);
         chk("rnd_in_ready",   32'(in_ready),   32'd0);
         chk("rnd_salt_out",   32'(salt_out),   32'(salt));
      end
      @(negedge CLK);
      done_cyc = cyc;
      chk("done_out_valid",  32'(out_valid),  32'd1);
      chk("done_round_en",   32'(round_en),   32'd0);
      chk("done_key_shift2", 32'(key_shift2), 32'd0);
      chk("done_iter_end",   32'(iter_end),   32'd0);
      chk("done_round_num",  32'(round_num),  32'd15);
      chk("done_iter_num",   32'(iter_num),   32'd24);
      chk("done_salt_out",   32'(salt_out),   32'(salt));
   endtask

   initial begin
      int d1, d2, d3, d4, stray;
      RESET = 1'b0; in_valid = 1'b0; salt_in = 12'h000; out_ready = 1'b0;

      // asynchronous reset asserted mid-clock
      #3 RESET = 1'b1;
      #1 chk_reset_vals();
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("idle_round_en", 32'(round_en), 32'd0);
         chk("idle_in_ready", 32'(in_ready), 32'd1);
      end

      // single job, one-cycle in_valid
      in_valid = 1'b1; salt_in = 12'h5A3; out_ready = 1'b1;
      @(posedge CLK); #1 in_valid = 1'b0; salt_in = 12'h000;
      follow_job(12'h5A3, d1);
      @(negedge CLK);
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready",  32'(in_ready),  32'd1);
      chk("post_round_en",  32'(round_en),  32'd0);
      chk("post_salt_out",  32'(salt_out),  32'h5A3);

      // back-to-back: in_valid held, salt changes while busy
      in_valid = 1'b1; salt_in = 12'h001;
      @(posedge CLK); #1 salt_in = 12'hFFF;
      follow_job(12'h001, d1);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      follow_job(12'hFFF, d2);
      chk("b2b_spacing", 32'(d2 - d1), 32'd402);

      // third job accepted back-to-back, then stalled at completion
      salt_in = 12'h123;
      @(posedge CLK); #1 out_ready = 1'b0;
      follow_job(12'h123, d3);
      chk("b2b2_spacing", 32'(d3 - d2), 32'd402);
      salt_in = 12'h456;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
         chk("stall_salt_out",  32'(salt_out),  32'h123);
         chk("stall_round_en",  32'(round_en),  32'd0);
         chk("stall_round_num", 32'(round_num), 32'd15);
         chk("stall_iter_num",  32'(iter_num),  32'd24);
      end
      out_ready = 1'b1;
      #1 chk("stall_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge CLK); #1 in_valid = 1'b0;
      follow_job(12'h456, d4);
      @(negedge CLK);
      chk("stall_job_idle", 32'(in_ready), 32'd1);

      // reset mid-job at E0+200
      in_valid = 1'b1; salt_in = 12'h2B7;
      @(posedge CLK); #1 in_valid = 1'b0;
      for (int k = 1; k <= 200; k++) @(negedge CLK);
      chk("mid_round_en", 32'(round_en), 32'd1);
      #2 RESET = 1'b1;
      #1 chk_reset_vals();
      @(negedge CLK);
      RESET = 1'b0;
      stray = 0;
      for (int i = 0; i < 450; i++) begin
         @(negedge CLK);
         if (out_valid || round_en) stray++;
      end
      chk("abort_no_activity", 32'(stray), 32'd0);
      in_valid = 1'b1; salt_in = 12'h3C4;
      @(posedge CLK); #1 in_valid = 1'b0;
      follow_job(12'h3C4, d4);
      @(negedge CLK);
      chk("final_out_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
